armleo_rr_dispatcher: RTL and testbench
=======================================

# armleo_rr_dispatcher

Round-robin 1-to-N stream dispatcher: the distribution-side counterpart of the round-robin arbiter. It accepts one valid/ready input stream and hands each accepted word to exactly one of WIDTH output lanes. Lanes are served in rotating priority, and a lane that cannot accept is skipped. Each lane has a one-entry holding register, so outputs are registered. It sits in front of replicated workers such as cache banks or execution slots, and feeds them from a single producer.

## Interface
- WIDTH, 4: number of output lanes; must be ≥ 2.
- DATA_WIDTH, 32: payload width in bits.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input word present.
- in_ready, output, 1: dispatcher accepts the input word this cycle.
- in_data, input, DATA_WIDTH: input payload.
- in_lane_idx, output, $clog2(WIDTH): lane the current input word would go to; meaningful only when in_ready=1.
- out_valid, output, WIDTH: per-lane holding register full.
- out_ready, input, WIDTH: per-lane consumer accepts.
- out_data, output, WIDTH*DATA_WIDTH: lane i payload is in bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Lane free: `free[i] = !out_valid[i] || out_ready[i]`. A lane being drained this cycle counts as free.
- Rotation register `rotation` (0..WIDTH-1) names the highest-priority lane.
- Selection scans free lanes in order rotation, rotation+1, …, wrapping mod WIDTH. The first free lane found is `sel`.
- in_ready = |free. in_lane_idx = sel. When no lane is free, in_lane_idx is 0.
- Transfer on input: in_valid && in_ready.
  - On the next edge, lane sel loads in_data and sets out_valid[sel]=1.
  - rotation becomes (sel+1) mod WIDTH.
- Without an input transfer, rotation holds, even if lanes drain.
- Lane drain: out_valid[i] && out_ready[i] clears out_valid[i], unless the same lane is loaded that cycle. In that case out_valid stays 1 and the new data replaces the old.
- A word is never duplicated and never dropped.
- out_data[i] holds its value while out_valid[i]=1 and no load occurs.
- Several lanes may drain in the same cycle. At most one lane loads per cycle.

## Timing
- Reset values (asynchronous assertion): rotation=0, out_valid=0, out_data=0. Outputs are stable from the first edge after deassertion.
- Reset mid-operation discards all held words. Lane 0 becomes highest priority again.
- Latency: input transfer at edge k gives out_valid[sel]=1 from edge k onward (one cycle). Throughput is one word per cycle.
- in_ready and in_lane_idx are combinational from out_valid (registered) and out_ready. This is the only input-to-output combinational path.
- in_valid must not depend combinationally on in_ready.
- Once asserted, out_valid[i] stays high until that lane's drain handshake.
- Full: all out_valid=1 and out_ready=0 gives in_ready=0.
- Empty: all out_valid=0 gives in_ready=1 with sel=rotation.
- Wrap-around: sel=WIDTH-1 sets rotation to 0.

## Structure
- Shared package `armleo_rr_pkg`: localparam helpers for the index width ($clog2(WIDTH)), and the function `rr_next(idx, WIDTH)` that computes (idx+1) mod WIDTH. Both are shared with the arbiter.
- Sub-module `armleo_rr_pick`: combinational rotating priority picker.
  - Inputs: a WIDTH-bit mask and the rotation.
  - Outputs: one-hot pick, index, and any-set flag.
  - Implemented as double-width rotate, LSB-first scan, then rotate back.
- The top level holds the rotation register, the lane registers, and the handshake logic.

## Test plan
- WIDTH=4, DATA_WIDTH=8, out_ready=4'hF. Drive 0xA0..0xA5 back-to-back.
  - Words appear on lanes 0,1,2,3,0,1, one cycle after acceptance.
  - in_ready stays 1 throughout.
- out_ready=0. Push 0x10..0x13.
  - Lanes 0..3 fill and in_ready=0 while 0x14 waits.
  - Raise out_ready[2]: 0x14 loads lane 2 and rotation becomes 3.
- Skip: lane 1 full with out_ready[1]=0, rotation=1. Push 0x55.
  - in_lane_idx=2, 0x55 lands on lane 2, rotation becomes 3.
- Same-lane drain and load: lane 0 holds 0x01, out_ready[0]=1, rotation=0. Push 0x02.
  - Lane 0 shows 0x02 next cycle, with out_valid[0] continuously 1.
- Reset mid-operation: assert rst_n=0 asynchronously with 3 lanes full.
  - out_valid=0 immediately.
  - After release, the next word goes to lane 0.

Source files
------------

// File: rtl/armleo_rr_pkg.sv
// Shared round-robin helpers, used by both the dispatcher and the arbiter.
package armleo_rr_pkg;

  localparam int unsigned RR_MIN_WIDTH = 2;

  // Index width for a WIDTH-entry rotation; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // (idx + 1) mod width, valid for idx < width.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/armleo_rr_pick.sv
// Combinational rotating-priority picker: first set mask bit at or after rotation.
module armleo_rr_pick
  import armleo_rr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  input  logic [IDX_W-1:0] rotation,
  output logic [WIDTH-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [WIDTH-1:0] rotated;
  logic [WIDTH-1:0] first;
  logic             found;

  // Rotate right so the priority lane sits at bit 0, scan, then rotate back.
  assign rotated = WIDTH'({mask, mask} >> rotation);

  always_comb begin
    first = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (rotated[i] && !found) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign pick = WIDTH'(({first, first} << rotation) >> WIDTH);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pick[i]) idx = IDX_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/armleo_rr_dispatcher.sv
// Round-robin 1-to-N stream dispatcher with a one-entry holding register per lane.
module armleo_rr_dispatcher
  import armleo_rr_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [idx_width(WIDTH)-1:0]   in_lane_idx,
  output logic [WIDTH-1:0]              out_valid,
  input  logic [WIDTH-1:0]              out_ready,
  output logic [WIDTH*DATA_WIDTH-1:0]   out_data
);

  localparam int unsigned IDX_W = idx_width(WIDTH);

  logic [IDX_W-1:0]      rotation;
  logic [WIDTH-1:0]      free;
  logic [WIDTH-1:0]      sel_onehot;
  logic [IDX_W-1:0]      sel_idx;
  logic                  any_free;
  logic                  load;
  logic [DATA_WIDTH-1:0] lane_data [WIDTH];

  // A lane being drained this cycle can take the next word.
  assign free = ~out_valid | out_ready;

  armleo_rr_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask     (free),
    .rotation (rotation),
    .pick     (sel_onehot),
    .idx      (sel_idx),
    .any      (any_free)
  );

  assign in_ready    = any_free;
  assign in_lane_idx = sel_idx;
  assign load        = in_valid && any_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rotation <= '0;
    end else if (load) begin
      rotation <= IDX_W'(rr_next(32'(sel_idx), WIDTH));
    end
  end

  // Load wins over drain on the same lane, so out_valid stays set across it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) lane_data[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (load && sel_onehot[i]) begin
          out_valid[i] <= 1'b1;
          lane_data[i] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_data[i];
    end
  end

endmodule

// File: tb/tb_armleo_rr_dispatcher.sv
// Bench for armleo_rr_dispatcher: vector table, directed corner sequences, random vs model.
module tb_armleo_rr_dispatcher;

  localparam int W  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [1:0]      in_lane_idx;
  logic [W-1:0]    out_valid;
  logic [W-1:0]    out_ready;
  logic [W*DW-1:0] out_data;

  armleo_rr_dispatcher #(
    .WIDTH      (W),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_lane_idx (in_lane_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-lane occupancy, contents and the priority lane.
  bit        m_valid [W];
  logic [7:0] m_data [W];
  int        m_rot;

  typedef struct {
    bit         vld;
    logic [7:0] data;
    logic [3:0] ordy;
    bit         exp_ready;
    logic [1:0] exp_idx;
    logic [3:0] exp_valid;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_valid_vec();
    logic [3:0] v;
    for (int i = 0; i < W; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [31:0] m_data_vec();
    logic [31:0] v;
    for (int i = 0; i < W; i++) v[i*DW +: DW] = m_data[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_rot = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic step(input bit v, input logic [7:0] d, input logic [3:0] r,
                      output logic rdy_s, output logic [1:0] idx_s);
    int sel;
    @(negedge clk);
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
    sel = -1;
    for (int k = 0; k < W; k++) begin
      int j;
      j = (m_rot + k) % W;
      if ((!m_valid[j] || r[j]) && sel < 0) sel = j;
    end
    rdy_s = in_ready;
    idx_s = in_lane_idx;
    chk("in_ready", 32'(in_ready), 32'(sel >= 0));
    chk("in_lane_idx", 32'(in_lane_idx), (sel >= 0) ? 32'(sel) : 32'd0);
    for (int i = 0; i < W; i++) if (m_valid[i] && r[i]) m_valid[i] = 1'b0;
    if (v && sel >= 0) begin
      m_valid[sel] = 1'b1;
      m_data[sel]  = d;
      m_rot = (sel + 1) % W;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid_vec()));
    chk("out_data", out_data, m_data_vec());
  endtask

  initial begin
    logic       rdy;
    logic [1:0] idx;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = '0;
    model_reset();
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_in_lane_idx", 32'(in_lane_idx), 32'd0);

    // Back-to-back with all lanes ready, then fill with no consumer, then release lane 2.
    tbl.push_back('{1'b1, 8'hA0, 4'hF, 1'b1, 2'd0, 4'b0001});
    tbl.push_back('{1'b1, 8'hA1, 4'hF, 1'b1, 2'd1, 4'b0010});
    tbl.push_back('{1'b1, 8'hA2, 4'hF, 1'b1, 2'd2, 4'b0100});
    tbl.push_back('{1'b1, 8'hA3, 4'hF, 1'b1, 2'd3, 4'b1000});
    tbl.push_back('{1'b1, 8'hA4, 4'hF, 1'b1, 2'd0, 4'b0001});
    tbl.push_back('{1'b1, 8'hA5, 4'hF, 1'b1, 2'd1, 4'b0010});
    tbl.push_back('{1'b0, 8'h00, 4'hF, 1'b1, 2'd2, 4'b0000});
    tbl.push_back('{1'b1, 8'hA6, 4'hF, 1'b1, 2'd2, 4'b0100});
    tbl.push_back('{1'b1, 8'hA7, 4'hF, 1'b1, 2'd3, 4'b1000});
    tbl.push_back('{1'b0, 8'h00, 4'hF, 1'b1, 2'd0, 4'b0000});
    tbl.push_back('{1'b1, 8'h10, 4'h0, 1'b1, 2'd0, 4'b0001});
    tbl.push_back('{1'b1, 8'h11, 4'h0, 1'b1, 2'd1, 4'b0011});
    tbl.push_back('{1'b1, 8'h12, 4'h0, 1'b1, 2'd2, 4'b0111});
    tbl.push_back('{1'b1, 8'h13, 4'h0, 1'b1, 2'd3, 4'b1111});
    tbl.push_back('{1'b1, 8'h14, 4'h0, 1'b0, 2'd0, 4'b1111});
    tbl.push_back('{1'b1, 8'h14, 4'h4, 1'b1, 2'd2, 4'b1111});
    tbl.push_back('{1'b0, 8'h00, 4'hF, 1'b1, 2'd3, 4'b0000});

    foreach (tbl[n]) begin
      step(tbl[n].vld, tbl[n].data, tbl[n].ordy, rdy, idx);
      chk($sformatf("tbl%0d_ready", n), 32'(rdy), 32'(tbl[n].exp_ready));
      if (tbl[n].exp_ready) chk($sformatf("tbl%0d_idx", n), 32'(idx), 32'(tbl[n].exp_idx));
      chk($sformatf("tbl%0d_valid", n), 32'(out_valid), 32'(tbl[n].exp_valid));
    end

    // Skip: lane 1 held with no consumer, rotation at 1.
    do_reset();
    step(1'b1, 8'h40, 4'h0, rdy, idx);
    step(1'b1, 8'h41, 4'h0, rdy, idx);
    step(1'b1, 8'h42, 4'h0, rdy, idx);
    step(1'b1, 8'h43, 4'h0, rdy, idx);
    step(1'b1, 8'h44, 4'h1, rdy, idx);
    step(1'b0, 8'h00, 4'hD, rdy, idx);
    chk("skip_setup_valid", 32'(out_valid), 32'b0010);
    step(1'b1, 8'h55, 4'h0, rdy, idx);
    chk("skip_idx", 32'(idx), 32'd2);
    chk("skip_lane2_data", 32'(out_data[2*DW +: DW]), 32'h55);
    step(1'b0, 8'h00, 4'h0, rdy, idx);
    chk("skip_rotation", 32'(idx), 32'd3);

    // Same lane drained and reloaded in one cycle.
    do_reset();
    step(1'b1, 8'h01, 4'h0, rdy, idx);
    step(1'b1, 8'h03, 4'h0, rdy, idx);
    step(1'b1, 8'h04, 4'h0, rdy, idx);
    step(1'b1, 8'h05, 4'h0, rdy, idx);
    chk("same_pre_valid0", 32'(out_valid[0]), 32'd1);
    step(1'b1, 8'h02, 4'h1, rdy, idx);
    chk("same_idx", 32'(idx), 32'd0);
    chk("same_valid0", 32'(out_valid[0]), 32'd1);
    chk("same_data0", 32'(out_data[DW-1:0]), 32'h02);

    // Asynchronous reset with three lanes held.
    step(1'b0, 8'h00, 4'h8, rdy, idx);
    chk("rst_setup_valid", 32'(out_valid), 32'b0111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_data", out_data, 32'd0);
    model_reset();
    in_valid = 1'b0;
    out_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h77, 4'hF, rdy, idx);
    chk("rst_after_idx", 32'(idx), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom), rdy, idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
